// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset sequencer: owns the bus for reset-vector fetch and NMI/IRQ entry.
// Define INTSEQ_IRQ_EN to enable the maskable IRQ path; otherwise only reset and NMI exist.
module interrupt_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        irq,
    input  logic        nmi,
    input  logic        instr_boundary,
    input  logic        i_flag,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [6:0]  status_in,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        pc_load,
    output logic [15:0] pc_load_value,
    output logic        sp_dec,
    output logic        set_i,
    output logic        nmi_ack,
    output logic        irq_ack
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RST_VLO  = 4'd1,
        RST_VHI  = 4'd2,
        PUSH_PCH = 4'd3,
        PUSH_PCL = 4'd4,
        PUSH_P   = 4'd5,
        VLO      = 4'd6,
        VHI      = 4'd7,
        LOAD_PC  = 4'd8
    } state_t;

    state_t      state;
    logic        nmi_prev;
    logic        nmi_pend;
    logic        vec_nmi;
    logic        irq_take;
    logic        unused_in;
    logic [7:0]  sp_int;
    logic [7:0]  vec_lo;
    logic [7:0]  vec_hi;
    logic [15:0] pc_lat;
    logic [5:0]  status_lat;

`ifdef INTSEQ_IRQ_EN
    assign irq_take  = irq & ~i_flag;
    assign unused_in = status_in[4];
`else
    assign irq_take  = 1'b0;
    assign unused_in = status_in[4] ^ irq ^ i_flag;
`endif

    // Edge detector runs every clock so a short NMI pulse during a stall is not lost
    always_ff @(posedge clk) begin
        nmi_prev <= nmi;
        if (rst)
            nmi_pend <= 1'b0;
        else if (nmi && !nmi_prev)
            nmi_pend <= 1'b1;
        else if (clk_enable && state == VLO)
            nmi_pend <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RST_VLO;
            sp_int  <= 8'h00;
            vec_lo  <= 8'h00;
            vec_hi  <= 8'h00;
            vec_nmi <= 1'b0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (instr_boundary && (nmi_pend || irq_take)) begin
                        pc_lat     <= pc_in;
                        sp_int     <= sp_in;
                        status_lat <= {status_in[6:5], status_in[3:0]};
                        state      <= PUSH_PCH;
                    end
                end
                RST_VLO: begin
                    vec_lo <= data_in;
                    state  <= RST_VHI;
                end
                RST_VHI: begin
                    vec_hi <= data_in;
                    state  <= LOAD_PC;
                end
                PUSH_PCH: begin
                    sp_int <= sp_int - 8'd1;
                    state  <= PUSH_PCL;
                end
                PUSH_PCL: begin
                    sp_int <= sp_int - 8'd1;
                    state  <= PUSH_P;
                end
                PUSH_P: begin
                    sp_int <= sp_int - 8'd1;
                    state  <= VLO;
                end
                VLO: begin
                    vec_lo  <= data_in;
                    vec_nmi <= nmi_pend;
                    state   <= VHI;
                end
                VHI: begin
                    vec_hi <= data_in;
                    state  <= LOAD_PC;
                end
                LOAD_PC: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and strobe decode; B is always pushed as 0 with the unused bit 5 set
    always_comb begin
        busy          = (state != IDLE);
        addr          = 16'h0000;
        data_out      = 8'h00;
        rw            = 1'b1;
        pc_load       = 1'b0;
        pc_load_value = 16'h0000;
        sp_dec        = 1'b0;
        set_i         = 1'b0;
        nmi_ack       = 1'b0;
        irq_ack       = 1'b0;
        case (state)
            RST_VLO: addr = 16'hFFFC;
            RST_VHI: addr = 16'hFFFD;
            PUSH_PCH: begin
                addr     = {8'h01, sp_int};
                data_out = pc_lat[15:8];
                rw       = 1'b0;
                sp_dec   = 1'b1;
            end
            PUSH_PCL: begin
                addr     = {8'h01, sp_int};
                data_out = pc_lat[7:0];
                rw       = 1'b0;
                sp_dec   = 1'b1;
            end
            PUSH_P: begin
                addr     = {8'h01, sp_int};
                data_out = {status_lat[5:4], 1'b1, 1'b0, status_lat[3:0]};
                rw       = 1'b0;
                sp_dec   = 1'b1;
            end
            VLO: begin
                addr    = nmi_pend ? 16'hFFFA : 16'hFFFE;
                set_i   = 1'b1;
                nmi_ack = nmi_pend;
`ifdef INTSEQ_IRQ_EN
                irq_ack = ~nmi_pend;
`endif
            end
            VHI: addr = vec_nmi ? 16'hFFFB : 16'hFFFF;
            LOAD_PC: begin
                pc_load       = 1'b1;
                pc_load_value = {vec_hi, vec_lo};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset fetch, interrupt entry, hijack, SP wrap, stall, abort.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic        irq = 1'b0;
    logic        nmi = 1'b0;
    logic        instr_boundary = 1'b0;
    logic        i_flag = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  sp_in = 8'h00;
    logic [6:0]  status_in = 7'h00;
    logic [7:0]  data_in;
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        rw;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        sp_dec;
    logic        set_i;
    logic        nmi_ack;
    logic        irq_ack;

    int vectors = 0;
    int miscompares = 0;

    // Expected entry-vector details depend on which source drives the main entry test
    logic [15:0] e_vlo, e_vhi, e_vec;
    logic        e_nmi_ack, e_irq_ack;

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .irq(irq), .nmi(nmi),
        .instr_boundary(instr_boundary), .i_flag(i_flag), .pc_in(pc_in), .sp_in(sp_in),
        .status_in(status_in), .data_in(data_in), .busy(busy), .addr(addr),
        .data_out(data_out), .rw(rw), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .sp_dec(sp_dec), .set_i(set_i), .nmi_ack(nmi_ack), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'hBC;
            16'hFFFB: return 8'h9A;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'hEF;
            16'hFFFF: return 8'hBE;
            default:  return 8'h00;
        endcase
    endfunction

    always_comb data_in = mem_rd(addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    initial begin
`ifdef INTSEQ_IRQ_EN
        e_vlo = 16'hFFFE; e_vhi = 16'hFFFF; e_vec = 16'hBEEF;
        e_nmi_ack = 1'b0; e_irq_ack = 1'b1;
`else
        e_vlo = 16'hFFFA; e_vhi = 16'hFFFB; e_vec = 16'h9ABC;
        e_nmi_ack = 1'b1; e_irq_ack = 1'b0;
`endif
        // Reset state
        tick(); tick();
        chk("rst_busy", {15'd0, busy}, 16'd1);
        chk("rst_addr", addr, 16'hFFFC);
        chk("rst_rw", {15'd0, rw}, 16'd1);
        chk("rst_data_out", {8'd0, data_out}, 16'd0);
        chk("rst_strobes", {10'd0, pc_load, sp_dec, set_i, nmi_ack, irq_ack, 1'b0}, 16'd0);
        chk("rst_pcval", pc_load_value, 16'h0000);

        // Reset vector fetch
        rst = 1'b0;
        tick();
        chk("rvhi_addr", addr, 16'hFFFD);
        tick();
        chk("rload_pc_load", {15'd0, pc_load}, 16'd1);
        chk("rload_value", pc_load_value, 16'h1234);
        chk("rload_no_sp_dec", {14'd0, sp_dec, set_i}, 16'd0);
        tick();
        chk("ridle_busy", {15'd0, busy}, 16'd0);
        chk("ridle_addr", addr, 16'h0000);

        // Masked IRQ
        irq = 1'b1; i_flag = 1'b1; instr_boundary = 1'b1;
        tick();
        chk("masked_irq_busy", {15'd0, busy}, 16'd0);
`ifndef INTSEQ_IRQ_EN
        i_flag = 1'b0;
        tick();
        chk("irq_ignored_busy", {15'd0, busy}, 16'd0);
`endif
        irq = 1'b0; i_flag = 1'b0; instr_boundary = 1'b0;
        tick();

        // Main entry: PC=$C005 SP=$FD status=1000011
        pc_in = 16'hC005; sp_in = 8'hFD; status_in = 7'b1000011;
`ifdef INTSEQ_IRQ_EN
        irq = 1'b1;
`else
        nmi = 1'b1;
        tick();
`endif
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0; irq = 1'b0;
        pc_in = 16'h0000; sp_in = 8'h00; status_in = 7'h00;
        chk("pch_addr", addr, 16'h01FD);
        chk("pch_data", {8'd0, data_out}, 16'h00C0);
        chk("pch_rw_spdec", {14'd0, rw, sp_dec}, 16'h0001);
        tick();
        chk("pcl_addr", addr, 16'h01FC);
        chk("pcl_data", {8'd0, data_out}, 16'h0005);
        tick();
        chk("pp_addr", addr, 16'h01FB);
        chk("pp_data", {8'd0, data_out}, 16'h00A3);
        chk("pp_spdec", {15'd0, sp_dec}, 16'd1);
        tick();
        chk("vlo_addr", addr, e_vlo);
        chk("vlo_rw_seti", {14'd0, rw, set_i}, 16'h0003);
        chk("vlo_acks", {14'd0, nmi_ack, irq_ack}, {14'd0, e_nmi_ack, e_irq_ack});
        chk("vlo_spdec", {15'd0, sp_dec}, 16'd0);
        tick();
        chk("vhi_addr", addr, e_vhi);
        chk("vhi_seti", {15'd0, set_i}, 16'd0);
        tick();
        chk("load_pc", {15'd0, pc_load}, 16'd1);
        chk("load_value", pc_load_value, e_vec);
        tick();
        chk("entry_idle", {15'd0, busy}, 16'd0);
        nmi = 1'b0;
        tick();

`ifdef INTSEQ_IRQ_EN
        // NMI hijack of an IRQ entry
        pc_in = 16'hC005; sp_in = 8'hFD; status_in = 7'b1000011;
        irq = 1'b1; instr_boundary = 1'b1;
        tick();
        irq = 1'b0; instr_boundary = 1'b0;
        tick();
        nmi = 1'b1;
        tick();
        tick();
        chk("hijack_addr", addr, 16'hFFFA);
        chk("hijack_acks", {14'd0, nmi_ack, irq_ack}, 16'h0002);
        tick(); tick(); tick();
        nmi = 1'b0; instr_boundary = 1'b1;
        tick();
        chk("hijack_pend_clear", {15'd0, busy}, 16'd0);
        instr_boundary = 1'b0;
        tick();
`endif

        // SP wrap on NMI entry, with a new NMI edge during VHI
        nmi = 1'b1;
        tick();
        pc_in = 16'h4321; sp_in = 8'h01; status_in = 7'h00; instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0; nmi = 1'b0;
        chk("wrap_pch", addr, 16'h0101);
        chk("wrap_pch_data", {8'd0, data_out}, 16'h0043);
        tick();
        chk("wrap_pcl", addr, 16'h0100);
        tick();
        chk("wrap_p", addr, 16'h01FF);
        chk("wrap_p_data", {8'd0, data_out}, 16'h0020);
        tick();
        tick();
        nmi = 1'b1;
        tick();
        chk("wrap_load", pc_load_value, 16'h9ABC);
        tick();
        chk("wrap_idle", {15'd0, busy}, 16'd0);

        // Pending NMI taken at next boundary; stall then reset mid-sequence
        pc_in = 16'h1234; sp_in = 8'h80; instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        chk("pend_taken", {15'd0, busy}, 16'd1);
        chk("pend_pch", addr, 16'h0180);
        clk_enable = 1'b0;
        tick(); tick();
        chk("stall_addr", addr, 16'h0180);
        chk("stall_data", {8'd0, data_out}, 16'h0012);
        chk("stall_spdec", {15'd0, sp_dec}, 16'd1);
        clk_enable = 1'b1;
        tick();
        chk("stall_pcl_addr", addr, 16'h017F);
        chk("stall_pcl_data", {8'd0, data_out}, 16'h0034);
        nmi = 1'b0;
        tick();
        chk("abort_pp_rw", {15'd0, rw}, 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_addr", addr, 16'hFFFC);
        chk("abort_rw", {15'd0, rw}, 16'd1);
        tick();
        chk("abort_vhi", addr, 16'hFFFD);
        chk("abort_vhi_rw", {15'd0, rw}, 16'd1);
        tick();
        chk("abort_load", pc_load_value, 16'h1234);
        tick();
        instr_boundary = 1'b1;
        tick();
        chk("abort_no_retry", {15'd0, busy}, 16'd0);
        instr_boundary = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Bus-mastering sequencer that owns the 6502 datapath during reset-vector fetch and NMI/IRQ entry. It sits beside `instruction_decode` and takes the address bus, R/W and the PC/SP load strobes away from it at instruction boundaries. It pushes PCH, PCL and P to page 1, sets the I flag, fetches the vector and reloads the PC. Decode must stall while `busy` is high.

## Interface
- No parameters.
- `clk` input 1 — system clock.
- `rst` input 1 — synchronous, active-high reset.
- `clk_enable` input 1 — state advances only on edges where this is high.
- `irq` input 1 — level-sensitive, active-high interrupt request.
- `nmi` input 1 — active-high; the rising edge requests an NMI.
- `instr_boundary` input 1 — decode is in opcode-fetch; an interrupt may be taken here.
- `i_flag` input 1 — current I flag.
- `pc_in` input 16 — current PC.
- `sp_in` input 8 — current SP.
- `status_in` input 7 — status bits {N,V,B,D,I,Z,C}, bit 6 down to bit 0.
- `data_in` input 8 — bus read data; valid in the same cycle its address is driven.
- `busy` output 1 — sequencer owns the bus; decode stalls.
- `addr` output 16 — bus address while `busy`.
- `data_out` output 8 — bus write data.
- `rw` output 1 — 1 = read, 0 = write.
- `pc_load` output 1 — one-cycle strobe that loads `pc_load_value` into the PC.
- `pc_load_value` output 16 — vector to load.
- `sp_dec` output 1 — decrement the SP register (one pulse per push).
- `set_i` output 1 — set the I flag (one pulse).
- `nmi_ack` output 1 — one-cycle pulse when the NMI vector is committed.
- `irq_ack` output 1 — one-cycle pulse when the IRQ vector is committed.

## Operation
- States:
  - Reset path: RST_VLO, RST_VHI.
  - Interrupt path: PUSH_PCH, PUSH_PCL, PUSH_P, VLO, VHI.
  - Common: LOAD_PC, IDLE.
- Reset path: RST_VLO → RST_VHI → LOAD_PC → IDLE.
- Interrupt path: IDLE → PUSH_PCH → PUSH_PCL → PUSH_P → VLO → VHI → LOAD_PC → IDLE.
- NMI edge detection:
  - `nmi` is sampled every `clk`, independent of `clk_enable`.
  - A rising edge sets `nmi_pend`.
  - `nmi_pend` clears only in the cycle the NMI vector is committed (VLO), or on reset.
- IRQ is not latched. It is taken when `irq`=1 and `i_flag`=0 in the boundary cycle.
- Takeover: in IDLE with `instr_boundary`=1 and `clk_enable`=1, if `nmi_pend` or a takeable IRQ is present:
  - latch `pc_in`, `sp_in` and `status_in`;
  - go to PUSH_PCH.
- The boundary cycle itself belongs to decode.
- Push states each drive `rw`=0, `sp_dec`=1 and `addr`={8'h01, sp_int}, then decrement sp_int (8-bit, $00 wraps to $FF):
  - PUSH_PCH: data = pc[15:8];
  - PUSH_PCL: data = pc[7:0];
  - PUSH_P: data = {N,V,1,0,D,I,Z,C} from the latched status, with B pushed as 0.
- VLO:
  - vector select is evaluated in this cycle: NMI if `nmi_pend`, else IRQ;
  - drives `addr` = $FFFA (NMI) or $FFFE (IRQ) with `rw`=1;
  - captures `data_in` into vec_lo;
  - pulses `set_i` and the matching ack.
- NMI hijack: an NMI edge arriving during PUSH_* promotes the sequence to the NMI vector, and only `nmi_ack` pulses.
- VHI: reads vector+1 and captures the high byte. RST_VLO and RST_VHI do the same at $FFFC and $FFFD.
- LOAD_PC: `pc_load`=1 with `pc_load_value`={vec_hi, vec_lo}. Reset does not push, decrement SP, set I or ack.
- Outputs are decoded from state and internal registers. Outside the listed states: `addr`=0, `data_out`=0, `rw`=1, all strobes 0.
- `busy` = (state ≠ IDLE).
- Unreachable state codes go to IDLE.

## Timing
- Reset:
  - `rst`=1 on a `clk` edge forces state to RST_VLO and clears `nmi_pend`, sp_int, vec_lo and vec_hi. This overrides `clk_enable` and any in-progress sequence; an aborted push is not retried.
  - Outputs after the reset edge: `busy`=1, `addr`=$FFFC, `rw`=1, `data_out`=0, `pc_load`=0, `pc_load_value`=0, `sp_dec`=0, `set_i`=0, `nmi_ack`=0, `irq_ack`=0.
- Reset sequence length: 3 enabled cycles to `pc_load`; IDLE on the 4th.
- Interrupt sequence length: 6 enabled cycles after the boundary cycle, with `pc_load` in the 6th.
- `clk_enable`=0 freezes state and all outputs (strobes are held, not re-pulsed). Downstream gates strobes with `clk_enable`.
- Simultaneous events:
  - NMI and IRQ together: NMI wins and the IRQ is dropped. If the IRQ is still asserted and I is clear after RTI, it is taken again.
  - NMI edge during VHI or LOAD_PC: stays pending and is taken at the next boundary.
- Bus data is sampled in the same cycle its address is presented (single-cycle memory).

## Configuration
- `INTSEQ_IRQ_EN` defined: full behaviour.
- Undefined: `irq` and `i_flag` are ignored, `irq_ack` is tied to 0, and only the reset and NMI paths exist.

## Test plan
- Reset vector: release `rst` with memory $FFFC=$34, $FFFD=$12 → `pc_load` with $1234 in the 3rd enabled cycle, then `busy`=0.
- IRQ entry:
  - setup: PC=$C005, SP=$FD, status=7'b1000011, `i_flag`=0, `irq`=1 at a boundary;
  - expected writes: $01FD←$C0, $01FC←$05, $01FB←$A3;
  - then `sp_dec`×3, `set_i`+`irq_ack` at $FFFE, and `pc_load` with the vector.
- Masked IRQ: `irq`=1 with `i_flag`=1 at a boundary → `busy` stays 0.
- NMI hijack: IRQ entry starts and `nmi` rises during PUSH_PCL → VLO reads $FFFA, `nmi_ack`=1, `irq_ack`=0, `nmi_pend` cleared.
- SP wrap: SP=$01 at NMI entry → pushes to $0101, $0100, $01FF.
- Reset mid-sequence: assert `rst` during PUSH_P → next state RST_VLO, no further writes; a `clk_enable`=0 stall mid-sequence holds `addr`/`data_out` unchanged.
